// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the RV32I integer pipe: opcodes, funct fields,
// ALU operation codes and result-select codes (also used by the execute unit).
package id_stage_pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [7:0] {
    ALU_NOP  = 8'h00,
    ALU_ADD  = 8'h01,
    ALU_SUB  = 8'h02,
    ALU_SLT  = 8'h03,
    ALU_SLTU = 8'h04,
    ALU_XOR  = 8'h05,
    ALU_OR   = 8'h06,
    ALU_AND  = 8'h07,
    ALU_SLL  = 8'h08,
    ALU_SRL  = 8'h09,
    ALU_SRA  = 8'h0A
  } aluop_e;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'd0,
    SEL_LOGIC = 3'd1,
    SEL_SHIFT = 3'd2,
    SEL_ARITH = 3'd3
  } alusel_e;

  // Result-select group implied by an ALU operation.
  function automatic alusel_e sel_of(aluop_e op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: return SEL_ARITH;
      ALU_XOR, ALU_OR, ALU_AND:            return SEL_LOGIC;
      ALU_SLL, ALU_SRL, ALU_SRA:           return SEL_SHIFT;
      default:                             return SEL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// Priority forwarding mux for one operand: x0 reads as zero, lowest-index
// matching source wins over the regfile, and reports whether that winner is
// a load still in flight.
module id_fwd_mux #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                    rd_en_i,
  input  logic [4:0]              addr_i,
  input  logic [XLEN-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  output logic [XLEN-1:0]         data_o,
  output logic                    load_hit_o
);

  logic found;

  // Scan sources youngest-first; the first match is taken.
  always_comb begin
    data_o     = rf_data_i;
    load_hit_o = 1'b0;
    found      = 1'b0;
    if (addr_i == '0) begin
      data_o = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd_wreg_i[i] && (fwd_wd_i[5*i +: 5] == addr_i)) begin
          found      = 1'b1;
          data_o     = fwd_wdata_i[XLEN*i +: XLEN];
          load_hit_o = fwd_is_load_i[i];
        end
      end
    end
    if (!rd_en_i) load_hit_o = 1'b0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I integer decode stage: decodes OP-IMM/OP/LUI/AUIPC, resolves operands
// through forwarding, stalls on load-use, and holds the micro-op in an ID/EX
// register with a valid/ready handshake, flush and a stall counter.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned NUM_FWD      = 2,
  parameter bit          SIGN_EXT_IMM = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic                    reg1_read_o,
  output logic                    reg2_read_o,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  input  logic                    flush_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              aluop_o,
  output logic [2:0]              alusel_o,
  output logic [XLEN-1:0]         reg1_o,
  output logic [XLEN-1:0]         reg2_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [XLEN-1:0]         pc_o,
  output logic                    instvalid_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  logic signed [31:0] u32;
  logic [XLEN-1:0] imm_s, imm_z, imm_i, imm_u, imm_sh;
  assign u32    = {inst_i[31:12], 12'h000};
  assign imm_s  = XLEN'($signed(inst_i[31:20]));
  assign imm_z  = XLEN'(inst_i[31:20]);
  assign imm_i  = SIGN_EXT_IMM ? imm_s : imm_z;
  assign imm_u  = XLEN'(u32);
  assign imm_sh = XLEN'(inst_i[24:20]);

  aluop_e          dec_aluop;
  logic            dec_valid, rd1_en, rd2_en;
  logic [XLEN-1:0] dec_op1, dec_op2;

  // Instruction decode; anything unrecognised collapses to a NOP with no reads.
  always_comb begin
    dec_aluop = ALU_NOP;
    dec_valid = 1'b1;
    rd1_en    = 1'b0;
    rd2_en    = 1'b0;
    dec_op1   = '0;
    dec_op2   = '0;
    case (opcode)
      OPC_OP_IMM: begin
        rd1_en  = 1'b1;
        dec_op2 = imm_i;
        case (funct3)
          F3_ADD_SUB: dec_aluop = ALU_ADD;
          F3_SLT:     dec_aluop = ALU_SLT;
          F3_SLTU:    dec_aluop = ALU_SLTU;
          F3_XOR:     dec_aluop = ALU_XOR;
          F3_OR:      dec_aluop = ALU_OR;
          F3_AND:     dec_aluop = ALU_AND;
          F3_SLL: begin
            dec_op2 = imm_sh;
            if (funct7 == F7_BASE) dec_aluop = ALU_SLL;
            else                   dec_valid = 1'b0;
          end
          default: begin
            dec_op2 = imm_sh;
            if (funct7 == F7_BASE)     dec_aluop = ALU_SRL;
            else if (funct7 == F7_ALT) dec_aluop = ALU_SRA;
            else                       dec_valid = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        rd1_en = 1'b1;
        rd2_en = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: dec_aluop = ALU_ADD;
            F3_SLL:     dec_aluop = ALU_SLL;
            F3_SLT:     dec_aluop = ALU_SLT;
            F3_SLTU:    dec_aluop = ALU_SLTU;
            F3_XOR:     dec_aluop = ALU_XOR;
            F3_SR:      dec_aluop = ALU_SRL;
            F3_OR:      dec_aluop = ALU_OR;
            default:    dec_aluop = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          dec_aluop = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          dec_aluop = ALU_SRA;
        end else begin
          dec_valid = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_op2   = imm_u;
        dec_aluop = ALU_OR;
      end
      OPC_AUIPC: begin
        dec_op1   = pc_i;
        dec_op2   = imm_u;
        dec_aluop = ALU_ADD;
      end
      default: dec_valid = 1'b0;
    endcase
    if (!dec_valid) begin
      dec_aluop = ALU_NOP;
      rd1_en    = 1'b0;
      rd2_en    = 1'b0;
      dec_op1   = '0;
      dec_op2   = '0;
    end
  end

  assign reg1_read_o = rd1_en;
  assign reg2_read_o = rd2_en;
  assign reg1_addr_o = inst_i[19:15];
  assign reg2_addr_o = inst_i[24:20];

  logic [XLEN-1:0] fwd1_data, fwd2_data;
  logic            ld_hit1, ld_hit2;

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .rd_en_i(rd1_en), .addr_i(reg1_addr_o), .rf_data_i(reg1_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_is_load_i(fwd_is_load_i), .data_o(fwd1_data), .load_hit_o(ld_hit1)
  );

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .rd_en_i(rd2_en), .addr_i(reg2_addr_o), .rf_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_is_load_i(fwd_is_load_i), .data_o(fwd2_data), .load_hit_o(ld_hit2)
  );

  logic hazard, accept;
  logic valid_q, valid_d, wreg_q, wreg_d, iv_q, iv_d;
  logic [7:0] aluop_q, aluop_d;
  logic [2:0] alusel_q, alusel_d;
  logic [4:0] wd_q, wd_d;
  logic [XLEN-1:0] reg1_q, reg1_d, reg2_q, reg2_d, pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hazard   = in_valid && (ld_hit1 || ld_hit2);
  assign in_ready = rst && !hazard && !flush_i && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // ID/EX next state: flush beats accept beats drain; stall counter saturates.
  always_comb begin
    valid_d  = valid_q;
    aluop_d  = aluop_q;
    alusel_d = alusel_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    pc_d     = pc_q;
    iv_d     = iv_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      aluop_d  = dec_aluop;
      alusel_d = sel_of(dec_aluop);
      reg1_d   = rd1_en ? fwd1_data : dec_op1;
      reg2_d   = rd2_en ? fwd2_data : dec_op2;
      wd_d     = dec_valid ? rd : '0;
      wreg_d   = dec_valid;
      pc_d     = pc_i;
      iv_d     = dec_valid;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (hazard && !flush_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // ID/EX register and stall counter, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      aluop_q  <= '0;
      alusel_q <= '0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      pc_q     <= '0;
      iv_q     <= 1'b1;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      pc_q     <= pc_d;
      iv_q     <= iv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign pc_o        = pc_q;
  assign instvalid_o = iv_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against
// a pattern-table reference model of decode, forwarding and handshake.
`define CHK(tag, o, e) begin tests++; if (64'(o) !== 64'(e)) begin fails++; $error("FAIL %s observed=%0h expected=%0h", tag, 64'(o), 64'(e)); end end

module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  localparam int NF = 2;
  localparam int KI = 0, KS = 1, KR = 2, KLUI = 3, KAU = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush_i, out_ready;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [NF-1:0]    fwd_wreg_i, fwd_is_load_i;
  logic [5*NF-1:0]  fwd_wd_i;
  logic [32*NF-1:0] fwd_wdata_i;
  logic        out_valid, wreg_o, instvalid_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic [15:0] stall_cnt_o;

  // Second instance: zero-extended immediates and a 2-bit stall counter.
  logic        z_in_ready, z_r1rd, z_r2rd, z_out_valid, z_wreg, z_iv;
  logic [4:0]  z_r1a, z_r2a, z_wd;
  logic [7:0]  z_aluop;
  logic [2:0]  z_alusel;
  logic [31:0] z_reg1, z_reg2, z_pc;
  logic [1:0]  z_stall;

  id_stage_pipe #(.XLEN(32), .NUM_FWD(NF), .SIGN_EXT_IMM(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_is_load_i(fwd_is_load_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .instvalid_o(instvalid_o),
    .stall_cnt_o(stall_cnt_o)
  );

  id_stage_pipe #(.XLEN(32), .NUM_FWD(NF), .SIGN_EXT_IMM(1'b0), .CNT_W(2)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(z_r1rd), .reg2_read_o(z_r2rd),
    .reg1_addr_o(z_r1a), .reg2_addr_o(z_r2a),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_is_load_i(fwd_is_load_i), .flush_i(flush_i),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .aluop_o(z_aluop), .alusel_o(z_alusel), .reg1_o(z_reg1), .reg2_o(z_reg2),
    .wd_o(z_wd), .wreg_o(z_wreg), .pc_o(z_pc), .instvalid_o(z_iv),
    .stall_cnt_o(z_stall)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [6:0] opc; int f3; int f7;
    logic [7:0] aop; logic [2:0] asel; int kind;
  } pat_t;
  pat_t pats[$];

  typedef struct {
    logic [7:0] aop; logic [2:0] asel;
    logic [31:0] r1, r2, pc; logic [4:0] wd;
    logic wreg, iv, re1, re2;
  } uop_t;

  bit          m_ov;
  uop_t        m_uop;
  logic [15:0] m_cnt;
  logic [1:0]  m_zcnt;
  logic [31:0] done_pc[$];
  bit          acc;
  int          n;

  // Legal encodings: opcode, funct3 (-1 any), funct7 (-1 any), expected op.
  function automatic void init_pats();
    pats.push_back('{7'h13, 0, -1, ALU_ADD,  SEL_ARITH, KI});
    pats.push_back('{7'h13, 2, -1, ALU_SLT,  SEL_ARITH, KI});
    pats.push_back('{7'h13, 3, -1, ALU_SLTU, SEL_ARITH, KI});
    pats.push_back('{7'h13, 4, -1, ALU_XOR,  SEL_LOGIC, KI});
    pats.push_back('{7'h13, 6, -1, ALU_OR,   SEL_LOGIC, KI});
    pats.push_back('{7'h13, 7, -1, ALU_AND,  SEL_LOGIC, KI});
    pats.push_back('{7'h13, 1, 0,  ALU_SLL,  SEL_SHIFT, KS});
    pats.push_back('{7'h13, 5, 0,  ALU_SRL,  SEL_SHIFT, KS});
    pats.push_back('{7'h13, 5, 32, ALU_SRA,  SEL_SHIFT, KS});
    pats.push_back('{7'h33, 0, 0,  ALU_ADD,  SEL_ARITH, KR});
    pats.push_back('{7'h33, 0, 32, ALU_SUB,  SEL_ARITH, KR});
    pats.push_back('{7'h33, 1, 0,  ALU_SLL,  SEL_SHIFT, KR});
    pats.push_back('{7'h33, 2, 0,  ALU_SLT,  SEL_ARITH, KR});
    pats.push_back('{7'h33, 3, 0,  ALU_SLTU, SEL_ARITH, KR});
    pats.push_back('{7'h33, 4, 0,  ALU_XOR,  SEL_LOGIC, KR});
    pats.push_back('{7'h33, 5, 0,  ALU_SRL,  SEL_SHIFT, KR});
    pats.push_back('{7'h33, 5, 32, ALU_SRA,  SEL_SHIFT, KR});
    pats.push_back('{7'h33, 6, 0,  ALU_OR,   SEL_LOGIC, KR});
    pats.push_back('{7'h33, 7, 0,  ALU_AND,  SEL_LOGIC, KR});
    pats.push_back('{7'h37, -1, -1, ALU_OR,  SEL_LOGIC, KLUI});
    pats.push_back('{7'h17, -1, -1, ALU_ADD, SEL_ARITH, KAU});
  endfunction

  // Operand value: oldest source first so the youngest match overrides.
  function automatic void opnd(input logic [4:0] a, input logic [31:0] rf,
                               output logic [31:0] v, output bit ld);
    v  = rf;
    ld = 1'b0;
    if (a == 5'd0) begin
      v = '0;
      return;
    end
    for (int i = NF - 1; i >= 0; i--) begin
      if (fwd_wreg_i[i] && fwd_wd_i[5*i +: 5] == a) begin
        v  = fwd_wdata_i[32*i +: 32];
        ld = fwd_is_load_i[i];
      end
    end
  endfunction

  function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                output uop_t u, output bit hz);
    int k = -1;
    bit l1, l2;
    logic [31:0] v1, v2;
    u = '{default: '0};
    u.pc = pc;
    hz = 1'b0;
    foreach (pats[j]) begin
      if (k < 0 && inst[6:0] == pats[j].opc &&
          (pats[j].f3 < 0 || inst[14:12] == pats[j].f3[2:0]) &&
          (pats[j].f7 < 0 || inst[31:25] == pats[j].f7[6:0])) k = j;
    end
    if (k < 0) return;
    u.iv = 1'b1; u.wreg = 1'b1; u.wd = inst[11:7];
    u.aop = pats[k].aop; u.asel = pats[k].asel;
    opnd(inst[19:15], reg1_data_i, v1, l1);
    opnd(inst[24:20], reg2_data_i, v2, l2);
    case (pats[k].kind)
      KI: begin u.re1 = 1'b1; u.r1 = v1; u.r2 = {{20{inst[31]}}, inst[31:20]}; hz = l1; end
      KS: begin u.re1 = 1'b1; u.r1 = v1; u.r2 = {27'h0, inst[24:20]}; hz = l1; end
      KR: begin u.re1 = 1'b1; u.re2 = 1'b1; u.r1 = v1; u.r2 = v2; hz = l1 || l2; end
      KLUI: begin u.r1 = '0; u.r2 = {inst[31:12], 12'h0}; end
      default: begin u.r1 = pc; u.r2 = {inst[31:12], 12'h0}; end
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    pat_t p;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    p = pats[$urandom_range(0, 32'(pats.size() - 1))];
    w[6:0] = p.opc;
    if (p.f3 >= 0) w[14:12] = p.f3[2:0];
    if (p.f7 >= 0) w[31:25] = p.f7[6:0];
    w[19:15] = 5'($urandom_range(0, 3));
    if (p.kind == KR) w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic clear_fwd();
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_is_load_i = '0;
  endtask

  task automatic check_out();
    `CHK("out_valid", out_valid, m_ov);
    `CHK("z_out_valid", z_out_valid, m_ov);
    `CHK("stall_cnt", stall_cnt_o, m_cnt);
    `CHK("z_stall_cnt", z_stall, m_zcnt);
    if (m_ov) begin
      `CHK("aluop", aluop_o, m_uop.aop);
      `CHK("alusel", alusel_o, m_uop.asel);
      `CHK("reg1", reg1_o, m_uop.r1);
      `CHK("reg2", reg2_o, m_uop.r2);
      `CHK("wreg", wreg_o, m_uop.wreg);
      `CHK("instvalid", instvalid_o, m_uop.iv);
      `CHK("pc", pc_o, m_uop.pc);
      if (m_uop.iv) `CHK("wd", wd_o, m_uop.wd);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle(output bit accepted);
    uop_t u;
    bit hz, rdy;
    #1;
    model(inst_i, pc_i, u, hz);
    hz  = hz && in_valid;
    rdy = !hz && !flush_i && (!m_ov || out_ready);
    accepted = in_valid && rdy;
    `CHK("in_ready", in_ready, rdy);
    `CHK("reg1_addr", reg1_addr_o, inst_i[19:15]);
    `CHK("reg2_addr", reg2_addr_o, inst_i[24:20]);
    if (u.iv) begin
      `CHK("reg1_read", reg1_read_o, u.re1);
      `CHK("reg2_read", reg2_read_o, u.re2);
    end
    if (m_ov && out_ready && !flush_i) done_pc.push_back(m_uop.pc);
    if (hz && !flush_i) begin
      if (m_cnt != 16'hFFFF) m_cnt++;
      if (m_zcnt != 2'd3) m_zcnt++;
    end
    if (flush_i) m_ov = 1'b0;
    else if (accepted) begin m_ov = 1'b1; m_uop = u; end
    else if (out_ready) m_ov = 1'b0;
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic chk_reset();
    `CHK("rst_out_valid", out_valid, 1'b0);
    `CHK("rst_in_ready", in_ready, 1'b0);
    `CHK("rst_aluop", aluop_o, 8'h00);
    `CHK("rst_alusel", alusel_o, 3'd0);
    `CHK("rst_reg1", reg1_o, 32'h0);
    `CHK("rst_reg2", reg2_o, 32'h0);
    `CHK("rst_wd", wd_o, 5'd0);
    `CHK("rst_wreg", wreg_o, 1'b0);
    `CHK("rst_pc", pc_o, 32'h0);
    `CHK("rst_instvalid", instvalid_o, 1'b1);
    `CHK("rst_stall_cnt", stall_cnt_o, 16'h0);
    `CHK("rst_z_out_valid", z_out_valid, 1'b0);
    `CHK("rst_z_stall", z_stall, 2'd0);
  endtask

  initial begin
    init_pats();
    m_ov = 1'b0; m_cnt = '0; m_zcnt = '0;
    in_valid = 1'b1; out_ready = 1'b1; flush_i = 1'b0;
    inst_i = 32'h0000_0013; pc_i = '0;
    reg1_data_i = '0; reg2_data_i = '0;
    clear_fwd();

    // Held in reset across two edges.
    #21;
    chk_reset();
    rst = 1'b1;

    // ADDI x1,x0,-1: sign- and zero-extended immediate.
    inst_i = 32'hFFF0_0093; pc_i = 32'h100;
    cycle(acc);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $error("FAIL addi_out_valid %0h", out_valid); end
    tests++;
    if (reg2_o !== 32'hFFFF_FFFF) begin fails++; $error("FAIL addi_reg2_sext %0h", reg2_o); end
    tests++;
    if (aluop_o !== 8'(ALU_ADD)) begin fails++; $error("FAIL addi_aluop %0h", aluop_o); end
    tests++;
    if (wd_o !== 5'd1) begin fails++; $error("FAIL addi_wd %0h", wd_o); end
    tests++;
    if (z_reg2 !== 32'h0000_0FFF) begin fails++; $error("FAIL addi_reg2_zext %0h", z_reg2); end

    // ADD x3,x1,x2 with both sources matching x1: youngest wins.
    inst_i = 32'h0020_81B3; pc_i = 32'h104;
    reg1_data_i = 32'h33; reg2_data_i = 32'h44;
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h22, 32'h11};
    cycle(acc);
    tests++;
    if (reg1_o !== 32'h11) begin fails++; $error("FAIL fwd_prio_reg1 %0h", reg1_o); end
    tests++;
    if (reg2_o !== 32'h44) begin fails++; $error("FAIL fwd_prio_reg2 %0h", reg2_o); end

    // ADD x3,x0,x2 with sources targeting x0: operand is zero.
    inst_i = 32'h0020_01B3; pc_i = 32'h108;
    fwd_wd_i = {5'd0, 5'd0};
    cycle(acc);
    tests++;
    if (reg1_o !== 32'h0) begin fails++; $error("FAIL x0_reg1 %0h", reg1_o); end

    // Load-use on x1 for two cycles, then the load data forwards.
    inst_i = 32'h0020_81B3; pc_i = 32'h10C;
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_wdata_i = {32'h0, 32'h55};
    fwd_is_load_i = 2'b01;
    cycle(acc);
    `CHK("lu_bubble", out_valid, 1'b0);
    cycle(acc);
    `CHK("lu_stall_cnt", stall_cnt_o, 16'd2);
    fwd_is_load_i = 2'b00;
    cycle(acc);
    `CHK("lu_fwd_reg1", reg1_o, 32'h55);
    `CHK("lu_stall_hold", stall_cnt_o, 16'd2);

    // Flush while a hazard is pending and the register is occupied.
    clear_fwd();
    out_ready = 1'b0;
    inst_i = 32'h0010_0293; pc_i = 32'h110;
    cycle(acc);
    inst_i = 32'h0020_81B3; pc_i = 32'h114;
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_is_load_i = 2'b01;
    flush_i = 1'b1;
    cycle(acc);
    `CHK("flush_out_valid", out_valid, 1'b0);
    `CHK("flush_stall_cnt", stall_cnt_o, 16'd2);
    flush_i = 1'b0;
    clear_fwd();

    // Illegal opcode still flows as a NOP.
    out_ready = 1'b1;
    inst_i = 32'h0000_007F; pc_i = 32'h118;
    cycle(acc);
    `CHK("ill_instvalid", instvalid_o, 1'b0);
    `CHK("ill_wreg", wreg_o, 1'b0);
    `CHK("ill_aluop", aluop_o, 8'h00);
    `CHK("ill_out_valid", out_valid, 1'b1);

    // Backpressure stream of 10 ADDIs: each consumed exactly once, in order.
    in_valid = 1'b0;
    cycle(acc);
    done_pc.delete();
    in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      inst_i = {12'(n + 1), 5'd0, 3'b000, 5'(n + 1), 7'h13};
      pc_i = 32'h200 + 32'(4 * n);
      out_ready = !(c >= 2 && c < 5);
      cycle(acc);
      if (acc) n++;
    end
    `CHK("bp_accepted", n, 10);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(acc);
    cycle(acc);
    `CHK("bp_consumed", done_pc.size(), 10);
    foreach (done_pc[i]) `CHK("bp_order", done_pc[i], 32'h200 + 32'(4 * i));

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      flush_i   = ($urandom_range(0, 19) == 0);
      inst_i    = rand_inst();
      pc_i      = $urandom & ~32'h3;
      reg1_data_i = $urandom;
      reg2_data_i = $urandom;
      for (int i = 0; i < NF; i++) begin
        fwd_wreg_i[i]          = 1'($urandom_range(0, 1));
        fwd_wd_i[5*i +: 5]     = 5'($urandom_range(0, 3));
        fwd_wdata_i[32*i +: 32] = $urandom;
        fwd_is_load_i[i]       = ($urandom_range(0, 3) == 0);
      end
      cycle(acc);
    end

    // Asynchronous reset mid-stream with a micro-op held.
    flush_i = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    clear_fwd();
    inst_i = 32'h0050_0393; pc_i = 32'h300;
    cycle(acc);
    `CHK("pre_rst_out_valid", out_valid, 1'b1);
    #1 rst = 1'b0;
    #1 chk_reset();
    m_ov = 1'b0; m_cnt = '0; m_zcnt = '0;
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    cycle(acc);
    `CHK("post_rst_accept", out_valid, 1'b1);
    `CHK("post_rst_reg2", reg2_o, 32'h5);
    `CHK("post_rst_wd", wd_o, 5'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Registered RV32I integer decode stage that sits between the fetch/IF-ID register and the execute unit. It decodes OP-IMM, OP, LUI and AUIPC instructions and resolves operands from the register file or from NUM_FWD forwarding sources. It detects load-use hazards and stalls on them, and launches decoded micro-ops into an internal ID/EX output register using a valid/ready handshake with flush support. It generalises the combinational decoder with parametrised width and forwarding depth, correct x0 handling, a sign-extension mode, a full ALU op set, and a stall performance counter.

## Interface
- XLEN, 32, datapath width
- NUM_FWD, 2, forwarding sources; index 0 is the youngest and has the highest priority
- SIGN_EXT_IMM, 1, 1 = I-type immediates sign-extended per ISA; 0 = legacy zero-extension
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset; state clears while rst==0
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage accepts an instruction this cycle
- pc_i  in  XLEN  instruction address
- inst_i  in  32  instruction word
- reg1_read_o, reg2_read_o  out  1 each  regfile read enables (combinational)
- reg1_addr_o, reg2_addr_o  out  5 each  inst_i[19:15], inst_i[24:20] (combinational)
- reg1_data_i, reg2_data_i  in  XLEN each  regfile read data, same cycle
- fwd_wreg_i  in  NUM_FWD  source i writes a register
- fwd_wd_i  in  5*NUM_FWD  destination of source i
- fwd_wdata_i  in  XLEN*NUM_FWD  result of source i
- fwd_is_load_i  in  NUM_FWD  source i result is not yet available (load in flight)
- flush_i  in  1  kill the in-flight and accepting instruction
- out_valid  out  1  ID/EX register holds a micro-op
- out_ready  in  1  execute consumes the micro-op
- aluop_o  out  8  ALU operation code
- alusel_o  out  3  result select
- reg1_o, reg2_o  out  XLEN each  resolved operands
- wd_o  out  5  destination register
- wreg_o  out  1  write enable
- pc_o  out  XLEN  pc of the micro-op
- instvalid_o  out  1  0 = illegal instruction
- stall_cnt_o  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- **Decode.** Opcode 0010011 covers ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. Opcode 0110011 covers ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Opcode 0110111 is LUI (reg1 = 0, reg2 = {imm[31:12], 12'h0}, OR). Opcode 0010111 is AUIPC (reg1 = pc_i, reg2 = U-imm, ADD).
- **Shift immediates.** reg1 = rs1 and reg2 = zero-extended shamt inst_i[24:20]. Any funct7 other than 0000000, or 0100000 on SRAI/SUB/SRA, is illegal.
- **Illegal instructions.** Issue a NOP: aluop 0, alusel 0, wreg 0, instvalid_o 0. The micro-op still flows, so out_valid is 1.
- **Operand resolution** (when the read enable is 1):
  - Address 0 yields 0.
  - Otherwise the lowest index i with fwd_wreg_i[i], fwd_wd_i[i] equal to the address and fwd_wd_i[i] != 0 supplies the operand.
  - Otherwise the regfile supplies it.
  - With the read enable at 0, the operand is the immediate/pc/0 as decoded.
- **Load-use hazard.** Asserted when in_valid is 1, a source is read with a nonzero address, and the winning matching source i has fwd_is_load_i[i] = 1.
- **Handshake.** in_ready = !hazard && !flush_i && (!out_valid || out_ready). The stage accepts when in_valid && in_ready. On accept, the ID/EX register loads and out_valid becomes 1.
- **Bubbles.** When out_ready = 1 with no accept, out_valid becomes 0. A bubble is therefore inserted on a hazard.
- **Stall counter.** stall_cnt_o increments on each cycle with hazard && in_valid && !flush_i, and saturates at all-ones.
- **Flush.** flush_i has priority: out_valid becomes 0 at the next edge and nothing is accepted that cycle.

## Timing
- Latency: accept at edge N gives out_valid = 1 and the micro-op after edge N. Operands are captured at the accept edge.
- Outputs hold stable while out_valid && !out_ready.
- Full throughput is one instruction per cycle when out_ready is held at 1.
- The regfile address and read outputs are combinational from inst_i, with zero added latency.
- Reset values (asynchronous, on rst falling or while low): out_valid 0, aluop_o 0, alusel_o 0, reg1_o 0, reg2_o 0, wd_o 0, wreg_o 0, pc_o 0, instvalid_o 1, stall_cnt_o 0. in_ready is 0 while in reset.
- Releasing reset mid-stream drops any in-flight micro-op. The first accept can occur on the first edge after rst rises.
- Simultaneous hazard and flush: the flush wins and the stall counter does not count.
- Simultaneous out_ready and accept: the register is replaced in one edge, with no bubble.

## Structure
- The shared package holds XLEN defaults, the opcode/funct3/funct7 constants, the aluop codes (NOP, ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA) and the alusel codes (NOP, LOGIC, SHIFT, ARITH). The execute unit uses the same package.
- Sub-module id_fwd_mux, instantiated twice, is the priority forwarding mux plus load-hit detect for one operand.
- The top level contains the decoder, handshake, ID/EX register and counter.

## Test plan
- **ADDI sign extension.** ADDI x1,x0,-1 (0xFFF00093), SIGN_EXT_IMM=1 → reg2_o 0xFFFFFFFF, aluop ADD, wd 1, one cycle later. With SIGN_EXT_IMM=0 → reg2_o 0x00000FFF.
- **Forwarding priority.** ADD x3,x1,x2 with fwd0 = (x1, 0x11) and fwd1 = (x1, 0x22), regfile 0x33 → reg1_o 0x11. With fwd_wd_i = 0 and rs = x0 → operand 0.
- **Load-use stall.** fwd0 = (x1, is_load=1) → in_ready 0 for 2 cycles, stall_cnt_o 2, out_valid drops to 0. Clearing is_load → accept, reg1_o = forwarded data.
- **Backpressure.** out_ready 0 for 3 cycles with the stream valid → outputs constant, in_ready 0, no instruction lost or duplicated over 10 instructions.
- **Flush during hazard.** Assert flush_i with out_valid 1 during a hazard → out_valid 0 next cycle, stall_cnt unchanged.
- **Illegal instruction and reset.** Illegal 0x0000007F → instvalid_o 0, wreg_o 0, out_valid 1. Assert rst low mid-stream → all outputs return to their reset values immediately, without waiting for a clock edge.
